// File: rtl/mm_setup_pkg.sv
// Shared definitions for the Montgomery setup engine: FSM encoding, default width
// and the iteration-counter width helper.
package mm_setup_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR,
        DONE
    } state_t;

    localparam int MM_W_DEFAULT = 16;

    // The counter has to hold values up to 2*W.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/mm_nprime_serial.sv
// Serial Hensel loop computing m = -n^-1 mod 2^W, one bit per step, LSB first.
// Used by mm_setup_gen only when MM_NPRIME_EN is defined.
module mm_nprime_serial
    import mm_setup_pkg::*;
#(
    parameter int W = MM_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] n,
    output logic [W-1:0] m
);

    logic [W:0] t_q;
    logic [W:0] t_sum;

    // t never exceeds n, so t + n always fits in W+1 bits.
    assign t_sum = t_q[0] ? (t_q + {1'b0, n}) : t_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q <= '0;
            m   <= '0;
        end else if (ce) begin
            if (load) begin
                t_q <= {{W{1'b0}}, 1'b1};
                m   <= '0;
            end else if (step) begin
                t_q <= t_sum >> 1;
                m   <= {t_q[0], m[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/mm_setup_gen.sv
// Montgomery setup engine: p = R^2 mod n (R = 2^W) by bit-serial double-and-subtract,
// with start/busy/ready/err handshake. Define MM_NPRIME_EN to also produce n' = -n^-1 mod 2^W.
module mm_setup_gen
    import mm_setup_pkg::*;
#(
    parameter int W = MM_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         start,
    input  logic [W-1:0] n,
    output logic [W-1:0] p,
    output logic [W-1:0] n_prime,
    output logic         busy,
    output logic         ready,
    output logic         err
);

    localparam int               CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(2 * W - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W:0]       r_q;
    logic [W:0]       r_next;
    logic [W+1:0]     r_dbl;
    logic             r_ge;
    logic [W-1:0]     n_q;
    logic             load_run, load_err, step, finish_ok, finish_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        load_run   = 1'b0;
        load_err   = 1'b0;
        step       = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (ce && start) begin
                    if (n[0]) begin
                        state_d  = RUN;
                        load_run = 1'b1;
                    end else begin
                        state_d  = ERR;
                        load_err = 1'b1;
                    end
                end
            end
            RUN: begin
                if (ce) begin
                    step = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d   = DONE;
                        finish_ok = 1'b1;
                    end
                end
            end
            ERR: begin
                if (ce) begin
                    state_d    = DONE;
                    finish_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // r < n holds throughout, so 2r < 2n and a single conditional subtract reduces it.
    always_comb begin
        r_dbl  = {1'b0, r_q, 1'b0};
        r_ge   = (r_dbl >= {2'b00, n_q});
        r_next = r_ge ? (r_dbl[W:0] - {1'b0, n_q}) : r_dbl[W:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            r_q   <= '0;
            n_q   <= '0;
            p     <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (load_run || load_err) begin
                n_q   <= n;
                cnt_q <= '0;
                // Start from 1 mod n, which is 0 for the degenerate modulus n = 1.
                r_q   <= (n == {{(W-1){1'b0}}, 1'b1}) ? '0 : {{W{1'b0}}, 1'b1};
                p     <= '0;
                busy  <= 1'b1;
                ready <= 1'b0;
                err   <= 1'b0;
            end
            if (step) begin
                r_q   <= r_next;
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish_ok) begin
                p     <= r_next[W-1:0];
                busy  <= 1'b0;
                ready <= 1'b1;
            end
            if (finish_err) begin
                p     <= '0;
                busy  <= 1'b0;
                ready <= 1'b1;
                err   <= 1'b1;
            end
        end
    end

`ifdef MM_NPRIME_EN
    localparam logic [CNT_W-1:0] HALF = CNT_W'(W);

    logic [W-1:0] m;
    logic         h_step;

    // The Hensel loop only needs the first W of the 2W iterations.
    assign h_step = step && (cnt_q < HALF);

    mm_nprime_serial #(.W(W)) u_nprime (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .load (load_run),
        .step (h_step),
        .n    (n_q),
        .m    (m)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      n_prime <= '0;
        else if (load_run || load_err) n_prime <= '0;
        else if (finish_ok)            n_prime <= m;
    end
`else
    assign n_prime = '0;
`endif

endmodule

// File: tb/tb_mm_setup_gen.sv
// Directed bench for mm_setup_gen at W=8, 16 and 32; build with MM_NPRIME_EN to check n_prime.
module tb_mm_setup_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        start16, start8, start32;
    logic [15:0] n16, p16, np16;
    logic [7:0]  n8, p8, np8;
    logic [31:0] n32, p32, np32;
    logic        busy16, ready16, err16;
    logic        busy8, ready8, err8;
    logic        busy32, ready32, err32;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mm_setup_gen #(.W(16)) d16 (
        .clk(clk), .rst(rst), .ce(ce), .start(start16), .n(n16),
        .p(p16), .n_prime(np16), .busy(busy16), .ready(ready16), .err(err16)
    );

    mm_setup_gen #(.W(8)) d8 (
        .clk(clk), .rst(rst), .ce(ce), .start(start8), .n(n8),
        .p(p8), .n_prime(np8), .busy(busy8), .ready(ready8), .err(err8)
    );

    mm_setup_gen #(.W(32)) d32 (
        .clk(clk), .rst(rst), .ce(ce), .start(start32), .n(n32),
        .p(p32), .n_prime(np32), .busy(busy32), .ready(ready32), .err(err32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // n_prime is checked by its defining property (n * n' + 1 == 0 mod 2^w), or tied to 0.
    task automatic check_np(input string tag, input int w, input logic [63:0] nv, input logic [63:0] np);
`ifdef MM_NPRIME_EN
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        check(tag, (nv * np + 64'd1) & mask, 64'd0);
`else
        check(tag, np, 64'd0);
`endif
    endtask

    function automatic logic [63:0] r2mod(input int w, input logic [63:0] nv);
        logic [63:0] r;
        r = (64'd1 << w) % nv;
        return (r * r) % nv;
    endfunction

    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go16(input logic [15:0] nv);
        n16 = nv; start16 = 1'b1;
        cycles(1);
        start16 = 1'b0;
    endtask

    initial begin
        logic [63:0] rn;

        rst = 1'b0; ce = 1'b1;
        start16 = 1'b0; start8 = 1'b0; start32 = 1'b0;
        n16 = '0; n8 = '0; n32 = '0;
        cycles(3);
        check("reset_p", p16, 0);
        check("reset_np", np16, 0);
        check("reset_busy", busy16, 0);
        check("reset_ready", ready16, 0);
        check("reset_err", err16, 0);
        rst = 1'b1;
        cycles(2);

        // Case 1: W=16, n=0x3317, ready exactly 32 cycles after capture.
        go16(16'h3317);
        check("c1_busy_set", busy16, 1);
        check("c1_ready_low", ready16, 0);
        cycles(31);
        check("c1_ready_early", ready16, 0);
        check("c1_busy_early", busy16, 1);
        cycles(1);
        check("c1_ready", ready16, 1);
        check("c1_busy_fall", busy16, 0);
        check("c1_p", p16, 16'h1A92);
        check("c1_err", err16, 0);
`ifdef MM_NPRIME_EN
        check("c1_np", np16, 16'hCB59);
`else
        check("c1_np", np16, 0);
`endif

        // Case 2: W=8, n=0xFB, ready after 16 cycles.
        n8 = 8'hFB; start8 = 1'b1;
        cycles(1);
        start8 = 1'b0;
        cycles(15);
        check("c2_ready_early", ready8, 0);
        cycles(1);
        check("c2_ready", ready8, 1);
        check("c2_p", p8, 8'h19);
        check("c2_err", err8, 0);
        check_np("c2_np", 8, 64'hFB, 64'(np8));

        // Case 3: even and zero modulus take the error path after one cycle.
        go16(16'h3316);
        check("c3_even_busy", busy16, 1);
        check("c3_even_ready_clr", ready16, 0);
        cycles(1);
        check("c3_even_ready", ready16, 1);
        check("c3_even_err", err16, 1);
        check("c3_even_p", p16, 0);
        check("c3_even_np", np16, 0);
        check("c3_even_busy_fall", busy16, 0);
        go16(16'h0000);
        cycles(1);
        check("c3_zero_ready", ready16, 1);
        check("c3_zero_err", err16, 1);
        check("c3_zero_p", p16, 0);
        go16(16'h3317);
        check("c3_err_clr", err16, 0);
        check("c3_ready_clr", ready16, 0);
        cycles(32);
        check("c3_rerun_ready", ready16, 1);
        check("c3_rerun_p", p16, 16'h1A92);

        // Case 4: ce toggling doubles latency; a mid-run start is ignored.
        go16(16'h3317);
        for (int c = 1; c <= 64; c++) begin
            ce      = (c % 2 == 0);
            start16 = (c == 20 || c == 21);
            n16     = (c == 20 || c == 21) ? 16'h0005 : 16'h3317;
            cycles(1);
            if (c == 63) check("c4_ready_early", ready16, 0);
        end
        start16 = 1'b0; ce = 1'b1;
        check("c4_ready", ready16, 1);
        check("c4_p", p16, 16'h1A92);
        check("c4_err", err16, 0);
        // Start with ce low is not captured.
        ce = 1'b0; start16 = 1'b1; n16 = 16'h0005;
        cycles(2);
        start16 = 1'b0; ce = 1'b1;
        check("c4_ce0_busy", busy16, 0);
        check("c4_ce0_ready", ready16, 1);
        check("c4_ce0_p", p16, 16'h1A92);

        // Case 5: reset mid-run abandons the run immediately.
        go16(16'h3317);
        cycles(9);
        check("c5_busy_before_rst", busy16, 1);
        rst = 1'b0;
        #1;
        check("c5_rst_busy", busy16, 0);
        check("c5_rst_ready", ready16, 0);
        check("c5_rst_err", err16, 0);
        check("c5_rst_p", p16, 0);
        cycles(1);
        rst = 1'b1;
        cycles(1);
        go16(16'h0001);
        cycles(32);
        check("c5_n1_ready", ready16, 1);
        check("c5_n1_p", p16, 0);
        check("c5_n1_err", err16, 0);
`ifdef MM_NPRIME_EN
        check("c5_n1_np", np16, 16'hFFFF);
`else
        check("c5_n1_np", np16, 0);
`endif

        // Case 6: random odd moduli against a reference model.
        for (int i = 0; i < 200; i++) begin
            rn = 64'($urandom_range(65535, 0) | 1);
            go16(rn[15:0]);
            cycles(32);
            check("c6_w16_ready", ready16, 1);
            check("c6_w16_p", p16, r2mod(16, rn));
            check_np("c6_w16_np", 16, rn, 64'(np16));
        end
        for (int i = 0; i < 200; i++) begin
            rn = 64'($urandom | 32'd1);
            n32 = rn[31:0]; start32 = 1'b1;
            cycles(1);
            start32 = 1'b0;
            cycles(64);
            check("c6_w32_ready", ready32, 1);
            check("c6_w32_p", p32, r2mod(32, rn));
            check_np("c6_w32_np", 32, rn, 64'(np32));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
